// File: rtl/rv32i_inst_encoder_pkg.sv
// Shared RV32I definitions: opcode/funct3 enumerations, instruction formats,
// field extraction and its inverse, field/immediate encoding.
package rv32i_inst_encoder_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_IMM    = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F,
    OPC_SYSTEM = 7'h73
  } opcode_e;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'd0,
    F3_SLL     = 3'd1,
    F3_SLT     = 3'd2,
    F3_SLTU    = 3'd3,
    F3_XOR     = 3'd4,
    F3_SRL_SRA = 3'd5,
    F3_OR      = 3'd6,
    F3_AND     = 3'd7
  } funct3_e;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  // Packed in R-type bit order so a raw word casts directly onto it.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } fields_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  function automatic fmt_e fmt_of(logic [6:0] op);
    fmt_e f;
    case (op)
      OPC_OP:                                    f = FMT_R;
      OPC_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:   f = FMT_I;
      OPC_STORE:                                 f = FMT_S;
      OPC_BRANCH:                                f = FMT_B;
      OPC_LUI, OPC_AUIPC:                        f = FMT_U;
      OPC_JAL:                                   f = FMT_J;
      default:                                   f = FMT_BAD;
    endcase
    return f;
  endfunction

  function automatic fields_t extract_fields(logic [31:0] word);
    return fields_t'(word);
  endfunction

  // Inverse of extract_fields: unused fields are left zero, immediate scattered.
  function automatic logic [31:0] encode_fields(fmt_e fmt, fields_t f, logic [31:0] imm);
    logic [31:0] w;
    w = '0;
    case (fmt)
      FMT_R: w = f;
      FMT_I: w = {imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      FMT_S: w = {imm[11:5], f.rs2, f.rs1, f.funct3, imm[4:0], f.opcode};
      FMT_B: w = {imm[12], imm[10:5], f.rs2, f.rs1, f.funct3, imm[4:1], imm[11], f.opcode};
      FMT_U: w = {imm[31:12], f.rd, f.opcode};
      FMT_J: w = {imm[20], imm[10:1], imm[11], imm[19:12], f.rd, f.opcode};
      default: w = NOP_WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rv32i_encoder_fifo.sv
// 2-entry in-order FIFO; ready derives from registered state only.
module rv32i_encoder_fifo #(
  parameter int unsigned DATA_W = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              alive_q, alive_d;
  logic              push, pop;

  assign push_ready = alive_q && (count_q != 2'd2);
  assign pop_valid  = (count_q != 2'd0);
  assign pop_data   = mem_q[rd_ptr_q];
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  // Next-state: write at wr_ptr, advance pointers, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    alive_d  = 1'b1;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the buffer and clears stored words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      alive_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      alive_q  <= alive_d;
    end
  end

endmodule

// File: rtl/rv32i_inst_encoder.sv
// RV32I instruction encoder: fields + immediate in, 32-bit word out through a
// 2-entry FIFO. Define RV32I_ENCODE_CHECK_EN to flag out-of-range immediates.
module rv32i_inst_encoder
  import rv32i_inst_encoder_pkg::*;
#(
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_opcode,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic                     out_error,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  fmt_e                     fmt;
  logic [31:0]              enc_word;
  logic                     enc_err;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  // Encode the presented fields and compute the error flag.
  always_comb begin
    fmt      = fmt_of(in_opcode);
    enc_word = encode_fields(fmt,
                 fields_t'({in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode}),
                 in_imm);
    enc_err  = (fmt == FMT_BAD);
`ifdef RV32I_ENCODE_CHECK_EN
    case (fmt)
      FMT_I: begin
        if ($signed(in_imm) < -2048 || $signed(in_imm) > 2047) enc_err = 1'b1;
        if (in_opcode == OPC_IMM &&
            (in_funct3 == F3_SLL || in_funct3 == F3_SRL_SRA) &&
            in_imm[11:5] != 7'h00 && in_imm[11:5] != 7'h20) enc_err = 1'b1;
      end
      FMT_S: if ($signed(in_imm) < -2048 || $signed(in_imm) > 2047) enc_err = 1'b1;
      FMT_B: if ($signed(in_imm) < -4096 || $signed(in_imm) > 4094 || in_imm[0]) enc_err = 1'b1;
      FMT_J: if ($signed(in_imm) < -1048576 || $signed(in_imm) > 1048574 || in_imm[0]) enc_err = 1'b1;
      FMT_U: if (in_imm[11:0] != 12'h000) enc_err = 1'b1;
      default: ;
    endcase
`endif
  end

  rv32i_encoder_fifo #(
    .DATA_W(33)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_valid(in_valid),
    .push_ready(in_ready),
    .push_data ({enc_err, enc_word}),
    .pop_valid (out_valid),
    .pop_ready (out_ready),
    .pop_data  ({out_error, out_inst})
  );

  assign err_count = err_cnt_q;

  // Saturating count of emitted error words.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_valid && out_ready && out_error && err_cnt_q != '1)
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
module tb_rv32i_inst_encoder;

  localparam int unsigned CW = 2;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, out_valid, out_ready, out_error;
  logic [6:0]    in_opcode, in_funct7;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [31:0]   in_imm, out_inst;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  rv32i_inst_encoder #(.ERR_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_error(out_error), .err_count(err_count)
  );

  typedef struct { logic [31:0] inst; logic err; } exp_t;
  typedef struct {
    logic [6:0] op; logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic [6:0] f7;
    logic [31:0] imm; logic [31:0] inst; logic err;
  } vec_t;

  exp_t        sbq[$];
  int unsigned model_err;
  bit          model_alive, after_reset, chk_en;
  logic [31:0] exp_inst;
  logic        exp_err;
  int          pass_cnt, total_cnt, dut_acc;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: word assembled arithmetically from field weights.
  function automatic void ref_enc(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] imm,
                                  output logic [31:0] inst, output logic err);
    longint unsigned w, im, base_rs;
    longint s;
    im = imm;
    s  = longint'($signed(imm));
    base_rs = longint'(rs1) * 2**15 + longint'(f3) * 2**12 + op;
    err = 1'b0;
    case (op)
      7'h33: w = longint'(f7) * 2**25 + longint'(rs2) * 2**20 + base_rs + longint'(rd) * 2**7;
      7'h13, 7'h03, 7'h67, 7'h73: w = (im % 4096) * 2**20 + base_rs + longint'(rd) * 2**7;
      7'h23: w = ((im / 32) % 128) * 2**25 + longint'(rs2) * 2**20 + base_rs + (im % 32) * 2**7;
      7'h63: w = ((im / 4096) % 2) * 2**31 + ((im / 32) % 64) * 2**25 + longint'(rs2) * 2**20
                 + base_rs + ((im / 2) % 16) * 2**8 + ((im / 2048) % 2) * 2**7;
      7'h37, 7'h17: w = (im / 4096) * 4096 + longint'(rd) * 128 + op;
      7'h6F: w = ((im / 2**20) % 2) * 2**31 + ((im / 2) % 1024) * 2**21 + ((im / 2048) % 2) * 2**20
                 + ((im / 4096) % 256) * 4096 + longint'(rd) * 128 + op;
      default: begin w = 32'h13; err = 1'b1; end
    endcase
    inst = w[31:0];
`ifdef RV32I_ENCODE_CHECK_EN
    case (op)
      7'h13, 7'h03, 7'h67, 7'h73, 7'h23: if (s < -2048 || s > 2047) err = 1'b1;
      7'h63: if (s < -4096 || s > 4094 || im % 2 == 1) err = 1'b1;
      7'h6F: if (s < -(64'sd1 << 20) || s > (64'sd1 << 20) - 2 || im % 2 == 1) err = 1'b1;
      7'h37, 7'h17: if (im % 4096 != 0) err = 1'b1;
      default: ;
    endcase
    if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5) &&
        (im / 32) % 128 != 0 && (im / 32) % 128 != 32) err = 1'b1;
`else
    if (s == 0 && f3 == 3'd0 && f7 == 7'd0) err = err; // fields only shape the word here
`endif
  endfunction

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic drive_random();
    logic [6:0] ops [10];
    logic [6:0] op;
    logic [31:0] imm;
    ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
    case ($urandom_range(0, 2))
      0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      1: imm = 32'($urandom) & 32'hFFFF_F000;
      default: imm = $urandom;
    endcase
    drive(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
    ref_enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, exp_inst, exp_err);
  endtask

  // One clock: compare DUT against the scoreboard, then advance the model.
  task automatic step();
    bit push, pop;
    exp_t e;
    #1;
    if (chk_en) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, model_alive && sbq.size() < 2});
      check("out_valid", {31'b0, out_valid}, {31'b0, sbq.size() > 0});
      check("err_count", 32'(err_count), model_err);
      if (sbq.size() > 0) begin
        check("out_inst", out_inst, sbq[0].inst);
        check("out_error", {31'b0, out_error}, {31'b0, sbq[0].err});
      end else if (after_reset) begin
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_error", {31'b0, out_error}, 32'h0);
      end
    end
    if (in_valid && in_ready === 1'b1) dut_acc++;
    push = model_alive && sbq.size() < 2 && in_valid;
    pop  = sbq.size() > 0 && out_ready;
    if (!rst_n) begin
      sbq.delete(); model_err = 0; model_alive = 0; after_reset = 1;
    end else begin
      if (pop) begin
        if (sbq[0].err && model_err < CMAX) model_err++;
        void'(sbq.pop_front());
      end
      if (push) begin e.inst = exp_inst; e.err = exp_err; sbq.push_back(e); end
      model_alive = 1; after_reset = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t tbl[10];

  initial begin
    int acc0;
    pass_cnt = 0; total_cnt = 0; dut_acc = 0; model_err = 0;
    model_alive = 0; after_reset = 0; chk_en = 0;
    tbl[0] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          32'h0050_0093, 1'b0};
    tbl[1] = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          32'h0020_A423, 1'b0};
    tbl[2] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,  32'h1234_52B7, 1'b0};
    tbl[3] = '{7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,          32'h0000_006F, 1'b0};
    tbl[4] = '{7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 7'd9, 32'd77,         32'h0000_0013, 1'b1};
`ifdef RV32I_ENCODE_CHECK_EN
    tbl[5] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h8000_0093, 1'b1};
`else
    tbl[5] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h8000_0093, 1'b0};
`endif
    tbl[6] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,          32'h0020_8463, 1'b0};
    tbl[7] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,          32'h0020_81B3, 1'b0};
    tbl[8] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF, 32'h4020_81B3, 1'b0};
    tbl[9] = '{7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF,  32'hFFF0_8093, 1'b0};

    rst_n = 0; in_valid = 0; out_ready = 1;
    drive(7'h13, 0, 0, 0, 0, 0, 0); exp_inst = 0; exp_err = 0;
    @(negedge clk);
    step();
    chk_en = 1;
    step();
    rst_n = 1;

    // Table vectors, one per cycle with output always ready.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1;
      drive(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].f3, tbl[i].f7, tbl[i].imm);
      exp_inst = tbl[i].inst; exp_err = tbl[i].err;
      step();
    end
    in_valid = 0;
    repeat (3) step();

    // Backpressure: 4 stalled cycles accept exactly two words, then drain in order.
    acc0 = dut_acc;
    out_ready = 0; in_valid = 1;
    repeat (4) begin drive_random(); step(); end
    check("stall_accepts", 32'(dut_acc - acc0), 32'd2);
    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 0; out_ready = 1;
    repeat (3) step();

    // Reset with two error words buffered: they must never appear.
    out_ready = 0; in_valid = 1;
    repeat (2) begin
      drive(7'h7F, 1, 1, 1, 0, 0, 0); exp_inst = 32'h13; exp_err = 1; step();
    end
    in_valid = 0; rst_n = 0;
    step();
    rst_n = 1; out_ready = 1;
    repeat (3) step();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive_random();
      step();
    end
    in_valid = 0; out_ready = 1;
    repeat (3) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
